mod_exp_ctrl: RTL and testbench

Square-and-multiply modular-exponentiation sequencer that drives a single Montgomery multiplier (MONT_MUL) as its initiator. It computes result = msg^exp mod n. It converts operands into the Montgomery domain, iterates over the exponent bits, and converts the result back out. It sits between the RSA host/control logic and the MONT_MUL datapath, owning MONT_MUL's start/finish handshake.

---
 rtl/mod_exp_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_mod_exp_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_exp_ctrl.sv
// Square-and-multiply modexp sequencer driving one Montgomery multiplier.
// Optional MODEXP_SKIP_LZ_EN: skip leading zero exponent bits before the loop.
module mod_exp_ctrl #(
    parameter int WIDTH     = 2048,
    parameter int EXP_WIDTH = 2048
) (
    input  logic                 clk,
    input  logic                 sys_rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     msg,
    input  logic [EXP_WIDTH-1:0] exp,
    input  logic [WIDTH-1:0]     n,
    input  logic [WIDTH-1:0]     r2,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic [WIDTH-1:0]     mm_x,
    output logic [WIDTH-1:0]     mm_y,
    output logic [WIDTH-1:0]     mm_n,
    output logic                 mm_rst,
    input  logic                 mm_finish,
    input  logic [WIDTH-1:0]     mm_result
);
    localparam int IDXW = $clog2(EXP_WIDTH) + 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_XBAR, S_ACC0, S_SQR, S_MUL, S_FINAL, S_DONE
`ifdef MODEXP_SKIP_LZ_EN
        , S_SCAN
`endif
    } state_t;

    // Per-call sub-handshake; SETUP loads operands, ISSUE is the mm_rst cycle.
    typedef enum logic [1:0] {PH_SETUP, PH_ISSUE, PH_GAP, PH_WAIT} phase_t;

    state_t                state_q, state_d;
    phase_t                phase_q, phase_d;
    logic [IDXW-1:0]       idx_q, idx_d;
    logic [EXP_WIDTH-1:0]  exp_q, exp_d;
    logic [WIDTH-1:0]      n_q, n_d, r2_q, r2_d;
    logic [WIDTH-1:0]      acc_q, acc_d, xbar_q, xbar_d;
    logic [WIDTH-1:0]      x_q, x_d, y_q, y_d, result_q, result_d;
    logic                  rst_q, rst_d, busy_q, busy_d, done_q, done_d;
    logic                  bit_set, last_bit;

    assign bit_set  = exp_q[idx_q[IDXW-2:0]];
    assign last_bit = (idx_q == '0);

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        idx_d    = idx_q;
        exp_d    = exp_q;
        n_d      = n_q;
        r2_d     = r2_q;
        acc_d    = acc_q;
        xbar_d   = xbar_q;
        x_d      = x_q;
        y_d      = y_q;
        rst_d    = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // First call issues straight from the inputs being latched.
                    exp_d   = exp;
                    n_d     = n;
                    r2_d    = r2;
                    x_d     = msg;
                    y_d     = r2;
                    rst_d   = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_XBAR;
                    phase_d = PH_ISSUE;
                end
            end
            S_DONE: begin
                done_d   = 1'b1;
                busy_d   = 1'b0;
                result_d = acc_q;
                state_d  = S_IDLE;
            end
`ifdef MODEXP_SKIP_LZ_EN
            S_SCAN: begin
                if (bit_set) begin
                    state_d = S_SQR;
                    phase_d = PH_SETUP;
                end else if (last_bit) begin
                    state_d = S_FINAL;
                    phase_d = PH_SETUP;
                end else begin
                    idx_d = idx_q - IDXW'(1);
                end
            end
`endif
            default: begin
                case (phase_q)
                    PH_SETUP: begin
                        rst_d   = 1'b1;
                        phase_d = PH_ISSUE;
                        case (state_q)
                            S_ACC0:  begin x_d = ONE;   y_d = r2_q;   end
                            S_SQR:   begin x_d = acc_q; y_d = acc_q;  end
                            S_MUL:   begin x_d = acc_q; y_d = xbar_q; end
                            default: begin x_d = acc_q; y_d = ONE;    end
                        endcase
                    end
                    PH_ISSUE: phase_d = PH_GAP;
                    PH_GAP:   phase_d = PH_WAIT;
                    default: begin
                        if (mm_finish) begin
                            phase_d = PH_SETUP;
                            case (state_q)
                                S_XBAR: begin
                                    xbar_d  = mm_result;
                                    state_d = S_ACC0;
                                end
                                S_ACC0: begin
                                    acc_d = mm_result;
                                    idx_d = IDXW'(EXP_WIDTH - 1);
`ifdef MODEXP_SKIP_LZ_EN
                                    state_d = (exp_q == '0) ? S_FINAL : S_SCAN;
`else
                                    state_d = S_SQR;
`endif
                                end
                                S_SQR: begin
                                    acc_d = mm_result;
                                    if (bit_set) begin
                                        state_d = S_MUL;
                                    end else if (last_bit) begin
                                        state_d = S_FINAL;
                                    end else begin
                                        idx_d = idx_q - IDXW'(1);
                                    end
                                end
                                S_MUL: begin
                                    acc_d = mm_result;
                                    if (last_bit) begin
                                        state_d = S_FINAL;
                                    end else begin
                                        idx_d   = idx_q - IDXW'(1);
                                        state_d = S_SQR;
                                    end
                                end
                                default: begin
                                    acc_d   = mm_result;
                                    state_d = S_DONE;
                                end
                            endcase
                        end
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= S_IDLE;
            phase_q  <= PH_SETUP;
            idx_q    <= '0;
            exp_q    <= '0;
            n_q      <= '0;
            r2_q     <= '0;
            acc_q    <= '0;
            xbar_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            rst_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            idx_q    <= idx_d;
            exp_q    <= exp_d;
            n_q      <= n_d;
            r2_q     <= r2_d;
            acc_q    <= acc_d;
            xbar_q   <= xbar_d;
            x_q      <= x_d;
            y_q      <= y_d;
            rst_q    <= rst_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign mm_x   = x_q;
    assign mm_y   = y_q;
    assign mm_n   = n_q;
    assign mm_rst = rst_q;
endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl with a behavioural Montgomery multiplier (R = 2^W, latency L).
module tb_mod_exp_ctrl;
    localparam int W  = 16;
    localparam int EW = 16;
    localparam int L  = 5;

    logic          clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  msg = '0, n = '0, r2 = '0;
    logic [EW-1:0] exp_i = '0;
    logic          busy, done, mm_rst;
    logic [W-1:0]  result, mm_x, mm_y, mm_n;
    logic          mm_finish = 1'b1;
    logic [W-1:0]  mm_result = '0;

    mod_exp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
        .clk(clk), .sys_rst_n(sys_rst_n), .start(start), .msg(msg), .exp(exp_i),
        .n(n), .r2(r2), .busy(busy), .done(done), .result(result),
        .mm_x(mm_x), .mm_y(mm_y), .mm_n(mm_n), .mm_rst(mm_rst),
        .mm_finish(mm_finish), .mm_result(mm_result)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    function automatic longint mont(input longint x, input longint y, input longint nn);
        longint t;
        t = x * y;
        for (int i = 0; i < W; i++) begin
            if (t[0]) t = t + nn;
            t = t >> 1;
        end
        while (t >= nn) t = t - nn;
        return t;
    endfunction

    function automatic logic [W-1:0] r2_of(input logic [W-1:0] nn);
        longint r;
        r = (longint'(1) << (2 * W)) % longint'(nn);
        return W'(r);
    endfunction

    function automatic longint modpow(input longint m, input logic [EW-1:0] e, input longint nn);
        longint r, b;
        r = 1;
        b = m % nn;
        for (int i = 0; i < EW; i++) begin
            if (e[i]) r = (r * b) % nn;
            b = (b * b) % nn;
        end
        return r;
    endfunction

    function automatic int calls_ref(input logic [EW-1:0] e);
        int bits;
        bits = EW;
`ifdef MODEXP_SKIP_LZ_EN
        bits = 0;
        for (int i = 0; i < EW; i++) if (e[i]) bits = i + 1;
`endif
        return 3 + bits + $countones(e);
    endfunction

    // Montgomery multiplier model: finish stays high until the next mm_rst is seen.
    int            mcnt = 0;
    int            mm_calls = 0;
    logic [W-1:0]  ox = '0, oy = '0, on_ = '0;
    always @(posedge clk) begin
        if (mm_rst) begin
            ox <= mm_x; oy <= mm_y; on_ <= mm_n;
            mcnt <= L;
            mm_finish <= 1'b0;
            mm_calls <= mm_calls + 1;
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) begin
                mm_finish <= 1'b1;
                mm_result <= W'(mont(longint'(ox), longint'(oy), longint'(on_)));
            end
        end
    end

    int   viol = 0;
    logic prev_rst = 1'b0;
    always @(negedge clk) begin
        if (sys_rst_n) begin
            if (mm_rst && prev_rst) begin
                viol <= viol + 1;
                $display("protocol: mm_rst high two cycles at %0t", $time);
            end
            if (busy && mcnt > 0 && (mm_x != ox || mm_y != oy || mm_n != on_)) begin
                viol <= viol + 1;
                $display("protocol: operands moved during wait at %0t", $time);
            end
        end
        prev_rst <= mm_rst;
    end

    task automatic chk(input string name, input longint act, input longint want);
        total++;
        if (act == want) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, want);
    endtask

    // Entered and left at a negedge; start is raised immediately (back-to-back).
    task automatic run_op(input logic [W-1:0] m, input logic [EW-1:0] e, input logic [W-1:0] nn,
                          input logic [W-1:0] want, input int want_calls, input string name,
                          input bit poke);
        int c0;
        bit seen;
        c0 = mm_calls;
        msg = m; exp_i = e; n = nn; r2 = r2_of(nn); start = 1'b1;
        @(negedge clk);
        start = 1'b0; msg = '1; exp_i = '1; n = W'(3); r2 = '0;
        chk({name, " busy after start"}, busy, 1);
        chk({name, " first mm_rst"}, mm_rst, 1);
        seen = 1'b0;
        for (int cyc = 0; cyc < 4000 && !seen; cyc++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (poke && cyc == 30) begin start = 1'b1; msg = W'(7); exp_i = EW'(3); end
            else if (poke && cyc == 31) begin start = 1'b0; msg = '1; end
        end
        start = 1'b0;
        chk({name, " done seen"}, seen, 1);
        chk({name, " result"}, result, want);
        chk({name, " busy low with done"}, busy, 0);
        chk({name, " mm calls"}, mm_calls - c0, want_calls);
        @(negedge clk);
        chk({name, " done single pulse"}, done, 0);
    endtask

    typedef struct {
        logic [W-1:0]  m;
        logic [EW-1:0] e;
        logic [W-1:0]  nn;
        logic [W-1:0]  res;
        int            calls_full;
        int            calls_skip;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{m: 16'd4,    e: 16'd13, nn: 16'd497,  res: 16'd445, calls_full: 22, calls_skip: 10};
        vecs[1] = '{m: 16'd2,    e: 16'd10, nn: 16'd1001, res: 16'd23,  calls_full: 21, calls_skip: 9};
        vecs[2] = '{m: 16'd999,  e: 16'd1,  nn: 16'd1001, res: 16'd999, calls_full: 20, calls_skip: 5};
        vecs[3] = '{m: 16'd4,    e: 16'd0,  nn: 16'd497,  res: 16'd1,   calls_full: 19, calls_skip: 3};
        vecs[4] = '{m: 16'd1000, e: 16'd2,  nn: 16'd1001, res: 16'd1,   calls_full: 20, calls_skip: 6};

        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset result", result, 0);
        chk("reset mm_rst", mm_rst, 0);
        chk("reset mm_x", mm_x, 0);
        chk("reset mm_y", mm_y, 0);
        chk("reset mm_n", mm_n, 0);
        repeat (2) @(negedge clk);
        sys_rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
`ifdef MODEXP_SKIP_LZ_EN
            run_op(vecs[i].m, vecs[i].e, vecs[i].nn, vecs[i].res, vecs[i].calls_skip, $sformatf("vec%0d", i), i == 0);
`else
            run_op(vecs[i].m, vecs[i].e, vecs[i].nn, vecs[i].res, vecs[i].calls_full, $sformatf("vec%0d", i), i == 0);
`endif
        end

        // Abort in the middle of a squaring call, then restart cleanly.
        begin
            int c0;
            c0 = mm_calls;
            msg = 16'd4; exp_i = 16'd13; n = 16'd497; r2 = r2_of(16'd497); start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int cyc = 0; cyc < 2000 && (mm_calls - c0) < 3; cyc++) @(negedge clk);
            chk("abort reached third call", mm_calls - c0, 3);
            repeat (3) @(negedge clk);
            sys_rst_n = 1'b0;
            #1;
            chk("abort busy", busy, 0);
            chk("abort done", done, 0);
            chk("abort mm_rst", mm_rst, 0);
            chk("abort result", result, 0);
            chk("abort mm_x", mm_x, 0);
            repeat (8) @(negedge clk);
            sys_rst_n = 1'b1;
            run_op(16'd2, 16'd10, 16'd1001, 16'd23, calls_ref(16'd10), "after abort", 1'b0);
        end

        for (int k = 0; k < 20; k++) begin
            logic [W-1:0]  nn, m;
            logic [EW-1:0] e;
            nn = W'($urandom_range(65535, 3)) | W'(1);
            m  = W'($urandom_range(int'(nn) - 1, 0));
            e  = EW'($urandom);
            if (k == 0) e = '1;
            run_op(m, e, nn, W'(modpow(longint'(m), e, longint'(nn))), calls_ref(e),
                   $sformatf("rand%0d", k), 1'b0);
        end

        chk("protocol violations", viol, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
